// File: rtl/fetch_redirect_unit.sv
// IF-stage PC generator: issues instruction fetches, applies EX fixes and ID
// taken predictions, drives pipeline flushes and counts branch events.
module fetch_redirect_unit #(
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                         CNT_WIDTH       = 32
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       stall_IF,
  input  logic                       predict_branch_taken_ID,
  input  logic [INST_ADDR_WIDTH-1:0] predict_branch_taken_PC_ID,
  input  logic                       fix_predict_EX,
  input  logic [INST_ADDR_WIDTH-1:0] fix_predict_PC_EX,
  input  logic                       branch_EX,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ready,
  output logic [INST_ADDR_WIDTH-1:0] PC_IF,
  output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF,
  output logic                       inst_valid_IF,
  output logic                       flush_IF_ID,
  output logic                       flush_ID_EX,
  output logic [CNT_WIDTH-1:0]       num_branch,
  output logic [CNT_WIDTH-1:0]       num_mispredict,
  output logic [CNT_WIDTH-1:0]       num_pred_taken
);

  // state         | meaning
  // BOOT          | first cycle after reset, no fetch request
  // FETCH         | fetching at PC_IF, redirects applied when memory is ready
  // REDIRECT_WAIT | redirect pending in pend_pc, in-flight word is discarded
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_REDIRECT_WAIT
  } state_t;

  state_t                     state;
  logic [INST_ADDR_WIDTH-1:0] pc_q;
  logic [INST_ADDR_WIDTH-1:0] pend_pc;
  logic                       req_q;

  logic                       accept_pred;
  logic                       redirect;
  logic [INST_ADDR_WIDTH-1:0] target_raw;
  logic [INST_ADDR_WIDTH-1:0] target;

  // A fix always wins; a prediction under stall is dropped and re-presented by ID.
  assign accept_pred = predict_branch_taken_ID && !stall_IF && !fix_predict_EX;
  assign redirect    = fix_predict_EX || accept_pred;
  assign target_raw  = fix_predict_EX ? fix_predict_PC_EX : predict_branch_taken_PC_ID;
  assign target      = {target_raw[INST_ADDR_WIDTH-1:2], 2'b00};

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign PC_IF         = pc_q;
  assign PC_plus_4_IF  = pc_q + INST_ADDR_WIDTH'(4);
  assign inst_valid_IF = (state == ST_FETCH) && imem_ready;
  assign flush_IF_ID   = redirect;
  assign flush_ID_EX   = fix_predict_EX;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state   <= ST_BOOT;
      pc_q    <= RESET_PC;
      pend_pc <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
          req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_q <= target;
            end else begin
              // Address must stay put while the request is outstanding.
              pend_pc <= target;
              state   <= ST_REDIRECT_WAIT;
            end
          end else if (imem_ready && !stall_IF) begin
            pc_q <= pc_q + INST_ADDR_WIDTH'(4);
          end
        end
        ST_REDIRECT_WAIT: begin
          if (imem_ready) begin
            pc_q  <= redirect ? target : pend_pc;
            state <= ST_FETCH;
          end else if (redirect) begin
            pend_pc <= target;
          end
        end
        default: begin
          state <= ST_BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      num_branch     <= '0;
      num_mispredict <= '0;
      num_pred_taken <= '0;
    end else begin
      if (branch_EX)      num_branch     <= num_branch + CNT_WIDTH'(1);
      if (fix_predict_EX) num_mispredict <= num_mispredict + CNT_WIDTH'(1);
      if (accept_pred)    num_pred_taken <= num_pred_taken + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_fetch_redirect_unit;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        stall_IF = 1'b0;
  logic        predict_branch_taken_ID = 1'b0;
  logic [31:0] predict_branch_taken_PC_ID = '0;
  logic        fix_predict_EX = 1'b0;
  logic [31:0] fix_predict_PC_EX = '0;
  logic        branch_EX = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] PC_IF;
  logic [31:0] PC_plus_4_IF;
  logic        inst_valid_IF;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic [31:0] num_branch;
  logic [31:0] num_mispredict;
  logic [31:0] num_pred_taken;

  fetch_redirect_unit #(
    .INST_ADDR_WIDTH(32),
    .RESET_PC(32'h0000_0000),
    .CNT_WIDTH(32)
  ) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst_n(cpu_rst_n),
    .stall_IF(stall_IF),
    .predict_branch_taken_ID(predict_branch_taken_ID),
    .predict_branch_taken_PC_ID(predict_branch_taken_PC_ID),
    .fix_predict_EX(fix_predict_EX),
    .fix_predict_PC_EX(fix_predict_PC_EX),
    .branch_EX(branch_EX),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .PC_IF(PC_IF),
    .PC_plus_4_IF(PC_plus_4_IF),
    .inst_valid_IF(inst_valid_IF),
    .flush_IF_ID(flush_IF_ID),
    .flush_ID_EX(flush_ID_EX),
    .num_branch(num_branch),
    .num_mispredict(num_mispredict),
    .num_pred_taken(num_pred_taken)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: booting/waiting flags, a PC and a pending target.
  bit          m_boot, m_wait;
  logic [31:0] m_pc, m_pend, m_nbr, m_nmis, m_npt;

  task automatic m_reset();
    m_boot = 1; m_wait = 0; m_pc = 0; m_pend = 0;
    m_nbr = 0; m_nmis = 0; m_npt = 0;
  endtask

  task automatic model_edge();
    bit          redir;
    logic [31:0] tgt;
    if (!cpu_rst_n) begin
      m_reset();
      return;
    end
    redir = fix_predict_EX || (predict_branch_taken_ID && !stall_IF);
    tgt   = ((fix_predict_EX ? fix_predict_PC_EX : predict_branch_taken_PC_ID) / 4) * 4;
    if (branch_EX) m_nbr = m_nbr + 1;
    if (fix_predict_EX) m_nmis = m_nmis + 1;
    else if (predict_branch_taken_ID && !stall_IF) m_npt = m_npt + 1;
    if (m_boot) m_boot = 0;
    else if (m_wait) begin
      if (imem_ready) begin
        m_pc   = redir ? tgt : m_pend;
        m_wait = 0;
      end else if (redir) m_pend = tgt;
    end else if (redir) begin
      if (imem_ready) m_pc = tgt;
      else begin
        m_pend = tgt;
        m_wait = 1;
      end
    end else if (imem_ready && !stall_IF) m_pc = m_pc + 4;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 32'(!m_boot));
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".pc"}, PC_IF, m_pc);
    chk({tag, ".pc4"}, PC_plus_4_IF, m_pc + 4);
    chk({tag, ".valid"}, 32'(inst_valid_IF), 32'(!m_boot && !m_wait && imem_ready));
    chk({tag, ".flush_if_id"}, 32'(flush_IF_ID),
        32'(fix_predict_EX || (predict_branch_taken_ID && !stall_IF)));
    chk({tag, ".flush_id_ex"}, 32'(flush_ID_EX), 32'(fix_predict_EX));
    chk({tag, ".nbr"}, num_branch, m_nbr);
    chk({tag, ".nmis"}, num_mispredict, m_nmis);
    chk({tag, ".npt"}, num_pred_taken, m_npt);
  endtask

  // Called at a negedge: drive inputs, let combinational outputs settle.
  task automatic apply(input bit st, input bit pr, input logic [31:0] ppc, input bit fx,
                       input logic [31:0] fpc, input bit br, input bit rdy);
    stall_IF = st; predict_branch_taken_ID = pr; predict_branch_taken_PC_ID = ppc;
    fix_predict_EX = fx; fix_predict_PC_EX = fpc; branch_EX = br; imem_ready = rdy;
    #1;
  endtask

  task automatic adv();
    @(posedge cpu_clk);
    model_edge();
    @(negedge cpu_clk);
  endtask

  task automatic do_reset();
    cpu_rst_n = 1'b0;
    stall_IF = 0; predict_branch_taken_ID = 0; fix_predict_EX = 0;
    branch_EX = 0; imem_ready = 0;
    m_reset();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
  endtask

  typedef struct {
    bit st, pr; logic [31:0] ppc; bit fx; logic [31:0] fpc; bit br, rdy;
    logic [31:0] e_pc; bit e_req, e_val, e_fif, e_fex;
    logic [31:0] e_nbr, e_nmis, e_npt;
  } vec_t;

  function automatic vec_t mk(bit st, bit pr, logic [31:0] ppc, bit fx, logic [31:0] fpc,
                              bit br, bit rdy, logic [31:0] e_pc, bit e_req, bit e_val,
                              bit e_fif, bit e_fex, logic [31:0] e_nbr,
                              logic [31:0] e_nmis, logic [31:0] e_npt);
    vec_t v;
    v.st = st; v.pr = pr; v.ppc = ppc; v.fx = fx; v.fpc = fpc; v.br = br; v.rdy = rdy;
    v.e_pc = e_pc; v.e_req = e_req; v.e_val = e_val; v.e_fif = e_fif; v.e_fex = e_fex;
    v.e_nbr = e_nbr; v.e_nmis = e_nmis; v.e_npt = e_npt;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    // Expected outputs are those seen during the row's cycle, before its clock edge.
    tbl[0]  = mk(0, 0, 0,      0, 0,      0, 1, 32'h000, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,      0, 0,      0, 1, 32'h000, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,      0, 0,      0, 1, 32'h004, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,      0, 0,      0, 1, 32'h008, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,      0, 0,      0, 1, 32'h00C, 1, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 'h40,   0, 0,      0, 1, 32'h010, 1, 1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 'h80,   1, 'h24,   1, 1, 32'h040, 1, 1, 1, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0,      1, 'h100,  1, 0, 32'h024, 1, 0, 1, 1, 1, 1, 1);
    tbl[8]  = mk(0, 0, 0,      0, 0,      0, 0, 32'h024, 1, 0, 0, 0, 2, 2, 1);
    tbl[9]  = mk(0, 0, 0,      0, 0,      0, 0, 32'h024, 1, 0, 0, 0, 2, 2, 1);
    tbl[10] = mk(0, 0, 0,      0, 0,      0, 1, 32'h024, 1, 0, 0, 0, 2, 2, 1);
    tbl[11] = mk(1, 1, 'h200,  0, 0,      0, 1, 32'h100, 1, 1, 0, 0, 2, 2, 1);
    tbl[12] = mk(1, 1, 'h200,  0, 0,      0, 1, 32'h100, 1, 1, 0, 0, 2, 2, 1);
    tbl[13] = mk(1, 1, 'h200,  1, 'h303,  1, 1, 32'h100, 1, 1, 1, 1, 2, 2, 1);
    tbl[14] = mk(0, 0, 0,      0, 0,      0, 1, 32'h300, 1, 1, 0, 0, 3, 3, 1);
    tbl[15] = mk(0, 0, 0,      0, 0,      0, 1, 32'h304, 1, 1, 0, 0, 3, 3, 1);

    // Reset state.
    @(negedge cpu_clk);
    #1;
    chk("rst.req", 32'(imem_req), 0);
    chk("rst.pc", PC_IF, 0);
    chk("rst.valid", 32'(inst_valid_IF), 0);
    chk("rst.flush", 32'({flush_IF_ID, flush_ID_EX}), 0);
    chk("rst.cnt", num_branch | num_mispredict | num_pred_taken, 0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].st, tbl[i].pr, tbl[i].ppc, tbl[i].fx, tbl[i].fpc, tbl[i].br, tbl[i].rdy);
      chk($sformatf("tbl%0d.pc", i), PC_IF, tbl[i].e_pc);
      chk($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].e_pc);
      chk($sformatf("tbl%0d.pc4", i), PC_plus_4_IF, tbl[i].e_pc + 32'd4);
      chk($sformatf("tbl%0d.req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d.valid", i), 32'(inst_valid_IF), 32'(tbl[i].e_val));
      chk($sformatf("tbl%0d.flush_if_id", i), 32'(flush_IF_ID), 32'(tbl[i].e_fif));
      chk($sformatf("tbl%0d.flush_id_ex", i), 32'(flush_ID_EX), 32'(tbl[i].e_fex));
      chk($sformatf("tbl%0d.nbr", i), num_branch, tbl[i].e_nbr);
      chk($sformatf("tbl%0d.nmis", i), num_mispredict, tbl[i].e_nmis);
      chk($sformatf("tbl%0d.npt", i), num_pred_taken, tbl[i].e_npt);
      adv();
    end

    // PC wrap: fix to an unaligned top address, then sequential fetch wraps to 0.
    apply(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 1);
    adv();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("wrap.pc", PC_IF, 32'hFFFF_FFFC);
    chk("wrap.pc4", PC_plus_4_IF, 32'h0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("wrap.next_pc", PC_IF, 32'h0);
    adv();

    // Reset asserted mid-cycle while a redirect is pending.
    apply(0, 0, 0, 1, 32'h500, 0, 0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("rwait.req", 32'(imem_req), 1);
    chk("rwait.addr", imem_addr, 32'h4);
    chk("rwait.nmis", num_mispredict, 32'd5);
    #1;
    cpu_rst_n = 1'b0;
    #1;
    chk("rwait.rst_req", 32'(imem_req), 0);
    chk("rwait.rst_pc", PC_IF, 32'h0);
    chk("rwait.rst_cnt", num_branch | num_mispredict | num_pred_taken, 0);
    adv();
    cpu_rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("rwait.boot_req", 32'(imem_req), 0);
    adv();
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("rwait.fetch_pc", PC_IF, 32'h0);
    chk("rwait.fetch_valid", 32'(inst_valid_IF), 1);
    adv();

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      apply($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7);
      check_model($sformatf("rnd%0d", c));
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Front-end PC generator and the consumer of the branch predictor's redirect interface.
- Holds the IF-stage PC and issues instruction-memory requests over a req/ready handshake.
- Arbitrates next-PC among EX-stage mispredict fixes, ID-stage taken predictions, stalls and sequential PC+4.
- Drives pipeline flushes and keeps branch performance counters.

Parameters:
INST_ADDR_WIDTH, 32, PC/address width
RESET_PC, 32'h0000_0000, PC loaded on reset
CNT_WIDTH, 32, width of each performance counter

Ports:
cpu_clk  input  1  clock
cpu_rst_n  input  1  asynchronous active-low reset
stall_IF  input  1  hazard-unit hold of IF/ID (load-use)
predict_branch_taken_ID  input  1  ID-stage branch predicted taken
predict_branch_taken_PC_ID  input  INST_ADDR_WIDTH  predicted target
fix_predict_EX  input  1  EX-stage misprediction detected
fix_predict_PC_EX  input  INST_ADDR_WIDTH  corrected PC
branch_EX  input  1  EX holds a conditional branch (counted)
imem_req  output  1  instruction fetch request
imem_addr  output  INST_ADDR_WIDTH  fetch address (= PC_IF)
imem_ready  input  1  fetch data valid this cycle
PC_IF  output  INST_ADDR_WIDTH  current fetch PC
PC_plus_4_IF  output  INST_ADDR_WIDTH  PC_IF+4 (wraps modulo 2^INST_ADDR_WIDTH)
inst_valid_IF  output  1  fetched word valid for IF/ID
flush_IF_ID  output  1  squash IF/ID contents
flush_ID_EX  output  1  squash ID/EX contents
num_branch  output  CNT_WIDTH  branches resolved
num_mispredict  output  CNT_WIDTH  fix_predict_EX events
num_pred_taken  output  CNT_WIDTH  accepted taken predictions

Behaviour:
- Reset (async assert, sync release): state=BOOT, PC_IF=RESET_PC, pend_pc=0, all counters 0.
- Reset outputs: imem_req=0, inst_valid_IF=0, both flushes 0.
- FSM states:
  - BOOT: imem_req=0; go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=PC_IF.
  - REDIRECT_WAIT: imem_req=1, address held; returned word is discarded.
- Redirect selection, combinational, same cycle:
  - fix_predict_EX=1 -> target=fix_predict_PC_EX. Overrides stall_IF and any concurrent prediction.
  - Else predict_branch_taken_ID=1 and stall_IF=0 -> target=predict_branch_taken_PC_ID.
  - A prediction during stall_IF is ignored; ID re-presents it next cycle.
  - Target bits [1:0] are forced to 0.
- Flushes are combinational and independent of state:
  - fix -> flush_IF_ID=1 and flush_ID_EX=1.
  - Accepted prediction -> flush_IF_ID=1 only.
- FETCH transitions:
  - Redirect with imem_ready=1 -> PC_IF<=target, stay FETCH.
  - Redirect with imem_ready=0 -> pend_pc<=target, go REDIRECT_WAIT. imem_addr must stay stable while req && !ready.
  - No redirect, imem_ready=1, stall_IF=0 -> PC_IF<=PC_IF+4.
  - Otherwise hold PC_IF.
- inst_valid_IF = (state==FETCH) && imem_ready.
- REDIRECT_WAIT transitions:
  - A new redirect overwrites pend_pc using the same priority.
  - On imem_ready=1, load the newest target this cycle (pend_pc or a same-cycle redirect) into PC_IF and go to FETCH.
  - inst_valid_IF=0 throughout.
- Redirect latency: PC_IF shows the target 1 cycle after the redirect cycle when imem_ready=1; otherwise 1 cycle after ready.
- Counters increment by 1 per cycle of their event and wrap at 2^CNT_WIDTH:
  - num_branch on branch_EX.
  - num_mispredict on fix_predict_EX.
  - num_pred_taken on an accepted prediction.
- Reset mid-wait aborts the pending redirect: pend_pc is discarded and PC_IF=RESET_PC.

Test Plan:
- Sequential fetch: release reset, imem_ready=1 always -> BOOT 1 cycle with req=0, then PC_IF=0,4,8,C on successive cycles; inst_valid_IF=1 from the first FETCH cycle.
- Prediction: at PC_IF=0x10 assert predict=1, target 0x40 -> flush_IF_ID=1, flush_ID_EX=0 that cycle; PC_IF=0x40 next cycle; num_pred_taken=1.
- Fix beats prediction: same cycle fix=1 (0x24) and predict=1 (0x80) -> both flushes=1; PC_IF=0x24 next; num_mispredict=1, num_pred_taken=0.
- Redirect under memory wait: imem_ready=0 at PC_IF=0x8 with fix to 0x100, ready stays low 3 cycles -> imem_addr held 0x8 throughout. When ready rises, inst_valid_IF=0 that cycle; PC_IF=0x100 the next cycle.
- Stall: stall_IF=1 for 2 cycles with predict=1 -> PC_IF held, no flush, counter unchanged. Fix during stall -> redirect taken.
- Wrap/reset: PC_IF=0xFFFF_FFFC with ready -> PC_plus_4_IF=0, next PC_IF=0. Asserting cpu_rst_n=0 mid-cycle in REDIRECT_WAIT immediately gives imem_req=0, PC_IF=RESET_PC, counters 0.
